// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } boot_state_t;

  localparam logic [7:0] BOOT_SYNC = 8'hA5;

  // States in which the loader is still consuming frame bytes.
  function automatic logic is_loading(boot_state_t s);
    return (s != ST_RUN) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/boot_loader_word_packer.sv
// Packs accepted payload bytes little-endian into 32-bit words and emits a
// one-cycle write strobe with the assembled word after every 4th byte.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_we,
  output logic [31:0] word_data
);

  logic [31:0] sr_q;
  logic [1:0]  idx_q;

  // Bytes shift in from the top so byte 0 ends up in lane [7:0].
  assign last_byte = byte_valid && (idx_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      idx_q     <= '0;
      word_we   <= 1'b0;
      word_data <= '0;
    end else begin
      word_we <= 1'b0;
      if (clear) begin
        idx_q <= '0;
      end else if (byte_valid) begin
        sr_q  <= {byte_data, sr_q[31:8]};
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          word_we   <= 1'b1;
          word_data <= {byte_data, sr_q[31:8]};
        end
      end
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Framed serial boot loader: writes an image into instruction memory and holds
// the core in reset until the image is complete. Checksum byte gated by BOOT_CSUM_EN.
//
// Handshake: a byte transfers on a rising clk edge when rx_valid && rx_ready;
// rx_ready is registered and never drops mid-frame, only on entering RUN/ERROR.
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              PCrst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int MAX_WORDS = 1 << ADDR_W;

  boot_state_t       state_q, state_d;
  logic [7:0]        len_lo_q;
  logic [ADDR_W:0]   n_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] addr_q;
  logic              rx_ready_q, core_rst_q, done_q, err_q;
  logic              hs, data_byte, word_last, clear;
  logic [15:0]       n_full;
  logic              len_bad;
`ifdef BOOT_CSUM_EN
  logic [7:0]        csum_q;
`endif

  assign hs        = rx_valid && rx_ready_q;
  assign data_byte = hs && (state_q == ST_DATA);
  assign n_full    = {rx_data, len_lo_q};
  assign len_bad   = (n_full == 16'd0) || ({16'd0, n_full} > 32'(MAX_WORDS));
  assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);

  word_packer u_packer (
    .clk        (clk),
    .rst        (PCrst),
    .clear      (clear),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .last_byte  (word_last),
    .word_we    (imem_we),
    .word_data  (imem_wdata)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      ST_SYNC:   if (hs && rx_data == BOOT_SYNC) state_d = ST_LEN_LO;
      ST_LEN_LO: if (hs) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (hs) begin
          if (len_bad) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
            clear   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (word_last && cnt_inc == n_q) begin
`ifdef BOOT_CSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_RUN;
`endif
        end
      end
      ST_CSUM: begin
`ifdef BOOT_CSUM_EN
        if (hs) state_d = (rx_data == csum_q) ? ST_RUN : ST_ERROR;
`else
        state_d = ST_ERROR;
`endif
      end
      default: state_d = state_q;
    endcase
  end

  // Status outputs are registered from the next state so they change one
  // cycle after the handshake that causes the transition.
  always_ff @(posedge clk or posedge PCrst) begin
    if (PCrst) begin
      state_q    <= ST_SYNC;
      rx_ready_q <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_lo_q   <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= is_loading(state_d);
      core_rst_q <= (state_d != ST_RUN);
      done_q     <= (state_d == ST_RUN);
      err_q      <= (state_d == ST_ERROR);
      if (hs && state_q == ST_LEN_LO) len_lo_q <= rx_data;
      if (hs && state_q == ST_LEN_HI) begin
        n_q   <= n_full[ADDR_W:0];
        cnt_q <= '0;
      end
      if (word_last) begin
        addr_q <= cnt_q[ADDR_W-1:0];
        cnt_q  <= cnt_inc;
      end
    end
  end

`ifdef BOOT_CSUM_EN
  always_ff @(posedge clk or posedge PCrst) begin
    if (PCrst) begin
      csum_q <= '0;
    end else if (hs && state_q == ST_LEN_HI) begin
      csum_q <= '0;
    end else if (data_byte) begin
      csum_q <= csum_q ^ rx_data;
    end
  end
`endif

  assign rx_ready  = rx_ready_q;
  assign imem_addr = addr_q;
  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
